// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
// Module      : result_writer
// Description : Writes an AXI4-Stream result packet into BRAM port A, bounds
//               it to DEPTH words, and raises a sticky done flag with the
//               packet length. Optional: RESULT_WRITER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module result_writer #(
    parameter int          DATA_WIDTH = 64,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] ADDR_BASE  = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                    S_AXIS_TVALID,
    input  logic                    S_AXIS_TLAST,
    output logic                    S_AXIS_TREADY,
    output logic [31:0]             bram_addra,
    output logic [DATA_WIDTH-1:0]   bram_dina,
    output logic                    bram_ena,
    output logic [DATA_WIDTH/8-1:0] bram_wea,
    input  logic                    done_ack,
    output logic                    done,
    output logic [15:0]             pkt_len,
    output logic                    overflow
`ifdef RESULT_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]   checksum
`endif
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] C_DEPTH   = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_wr;
    logic [31:0]      w_addr;
    logic             w_hs;
    logic             w_write;
    logic [15:0]      w_len_inc;

    assign w_hs = S_AXIS_TVALID && S_AXIS_TREADY;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (S_AXIS_TLAST)            w_state_nxt = S_DONE;
                    else if (C_DEPTH == C_IDX_ONE) w_state_nxt = S_DRAIN;
                    else                         w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (w_hs) begin
                    if (S_AXIS_TLAST)                      w_state_nxt = S_DONE;
                    else if ((r_idx + C_IDX_ONE) == C_DEPTH) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs && S_AXIS_TLAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (done_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // TREADY is held low during reset even though the state already reads IDLE.
    always_comb begin
        S_AXIS_TREADY = reset && (r_state != S_DONE);
        done          = (r_state == S_DONE);
        w_write       = 1'b0;
        if ((r_state == S_IDLE) || (r_state == S_RECV)) begin
            w_write = S_AXIS_TVALID && S_AXIS_TREADY;
        end
    end

    assign w_idx_wr  = (r_state == S_IDLE) ? '0 : r_idx;
    assign w_addr    = ADDR_BASE + ({{(32-IDX_W){1'b0}}, w_idx_wr} << 3);
    assign w_len_inc = (pkt_len == 16'hFFFF) ? pkt_len : pkt_len + 16'd1;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bram_ena   <= 1'b0;
            bram_wea   <= '0;
            bram_addra <= '0;
            bram_dina  <= '0;
            r_idx      <= '0;
            pkt_len    <= '0;
            overflow   <= 1'b0;
`ifdef RESULT_WRITER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            if (w_write) begin
                bram_ena   <= 1'b1;
                bram_wea   <= '1;
                bram_addra <= w_addr;
                bram_dina  <= S_AXIS_TDATA;
            end else begin
                bram_ena   <= 1'b0;
                bram_wea   <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_idx    <= C_IDX_ONE;
                        pkt_len  <= 16'd1;
                        overflow <= 1'b0;
`ifdef RESULT_WRITER_CHECKSUM_EN
                        checksum <= S_AXIS_TDATA;
`endif
                    end
                end
                S_RECV: begin
                    if (w_hs) begin
                        r_idx   <= r_idx + C_IDX_ONE;
                        pkt_len <= w_len_inc;
`ifdef RESULT_WRITER_CHECKSUM_EN
                        checksum <= checksum + S_AXIS_TDATA;
`endif
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        pkt_len  <= w_len_inc;
                        overflow <= 1'b1;
`ifdef RESULT_WRITER_CHECKSUM_EN
                        checksum <= checksum + S_AXIS_TDATA;
`endif
                    end
                end
                S_DONE: begin
                    if (done_ack) r_idx <= '0;
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_writer
// Description : Self-checking bench for result_writer: vector table, corner
//               sequences and random packets against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_writer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [31:0] bram_addra;
    logic [63:0] bram_dina;
    logic        bram_ena;
    logic [7:0]  bram_wea;
    logic        done_ack = 1'b0;
    logic        done;
    logic [15:0] pkt_len;
    logic        overflow;
`ifdef RESULT_WRITER_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    result_writer #(.DATA_WIDTH(64), .DEPTH(DEPTH), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .reset(reset),
        .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready),
        .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_ena(bram_ena), .bram_wea(bram_wea),
        .done_ack(done_ack), .done(done), .pkt_len(pkt_len), .overflow(overflow)
`ifdef RESULT_WRITER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int bad_wea = 0;
    logic [31:0] waddr_q[$];
    logic [63:0] wdata_q[$];
    logic [63:0] beats[$];

    // BRAM port-A observer: every enabled cycle is one committed word.
    always @(posedge clk) begin
        if (bram_ena) begin
            waddr_q.push_back(bram_addra);
            wdata_q.push_back(bram_dina);
            if (bram_wea != 8'hFF) bad_wea++;
        end else if (bram_wea != 8'h00) begin
            bad_wea++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        waddr_q.delete();
        wdata_q.delete();
        bad_wea = 0;
    endtask

    // Sends beats[0..stop-1] of an n-beat packet; gap 0=continuous,
    // 1=valid pattern 1,0,0,1, 2=random valid with random stray done_ack.
    task automatic send_pkt(input int n, input int gap, input int stop);
        int sent = 0;
        int cyc = 0;
        logic v;
        while (sent < stop && cyc < 5000) begin
            @(negedge clk);
            case (gap)
                0:       v = 1'b1;
                1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (gap == 2) done_ack = 1'($urandom_range(0, 1));
            tvalid = v;
            tdata  = beats[sent];
            tlast  = (sent == n - 1);
            if (sent == n - 1 && v && tready) check("done_early", done, 0);
            cyc++;
            if (v && tready) sent++;
        end
        if (sent < stop) check("send_timeout", sent, stop);
        if (stop == n) begin
            @(negedge clk);
            tvalid = 1'b0; tlast = 1'b0; done_ack = 1'b0;
            check("done_rise", done, 1);
            check("tready_in_done", tready, 0);
        end
    endtask

    // Packet-level model: first min(n,DEPTH) beats land at 8*i, rest dropped.
    task automatic verify(input int n, input int exp_wr, input int exp_len, input logic exp_ovf);
        logic [63:0] sum;
        int nw;
        sum = '0;
        @(negedge clk);
        check("write_count", waddr_q.size(), exp_wr);
        for (int i = 0; i < waddr_q.size() && i < exp_wr; i++) begin
            check("write_addr", waddr_q[i], 64'(8 * i));
            check("write_data", wdata_q[i], beats[i]);
        end
        check("wea_value", bad_wea, 0);
        check("done", done, 1);
        check("pkt_len", pkt_len, exp_len);
        check("overflow", overflow, exp_ovf);
`ifdef RESULT_WRITER_CHECKSUM_EN
        for (int i = 0; i < n; i++) sum = sum + beats[i];
        check("checksum", checksum, sum);
`endif
        nw = waddr_q.size();
        repeat (3) @(negedge clk);
        check("done_sticky", done, 1);
        check("tready_held_low", tready, 0);
        check("no_write_in_done", waddr_q.size(), nw);
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        check("done_cleared", done, 0);
        check("tready_after_ack", tready, 1);
        check("pkt_len_held", pkt_len, exp_len);
        clear_obs();
    endtask

    typedef struct {
        int          n;
        int          gap;
        logic [63:0] base;
        int          exp_wr;
        int          exp_len;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{20, 0, 64'd1100,  20, 20, 1'b0};
        vecs[1] = '{ 1, 0, 64'hABCD,   1,  1, 1'b0};
        vecs[2] = '{70, 0, 64'h5000,  64, 70, 1'b1};
        vecs[3] = '{ 8, 1, 64'h0700,   8,  8, 1'b0};
        vecs[4] = '{64, 0, 64'h9000,  64, 64, 1'b0};
        vecs[5] = '{65, 2, 64'hA000,  64, 65, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tready", tready, 0);
        check("rst_ena", bram_ena, 0);
        check("rst_wea", bram_wea, 0);
        check("rst_addr", bram_addra, 0);
        check("rst_dina", bram_dina, 0);
        check("rst_done", done, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_overflow", overflow, 0);
`ifdef RESULT_WRITER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        reset = 1'b1;
        @(negedge clk);
        check("idle_tready", tready, 1);
        // done_ack outside DONE has no effect
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        check("ack_in_idle", done, 0);
        clear_obs();

        for (int v = 0; v < 6; v++) begin
            beats.delete();
            for (int i = 0; i < vecs[v].n; i++) beats.push_back(vecs[v].base + 64'(i));
            send_pkt(vecs[v].n, vecs[v].gap, vecs[v].n);
            verify(vecs[v].n, vecs[v].exp_wr, vecs[v].exp_len, vecs[v].exp_ovf);
        end

        // Reset after beat 5 of a 10-beat packet
        beats.delete();
        for (int i = 0; i < 10; i++) beats.push_back(64'hC00 + 64'(i));
        send_pkt(10, 0, 5);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_tready", tready, 0);
        check("midrst_ena", bram_ena, 0);
        check("midrst_wea", bram_wea, 0);
        check("midrst_addr", bram_addra, 0);
        check("midrst_dina", bram_dina, 0);
        check("midrst_pkt_len", pkt_len, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_obs();
        beats.delete();
        for (int i = 0; i < 3; i++) beats.push_back(64'hD00 + 64'(i));
        send_pkt(3, 0, 3);
        verify(3, 3, 3, 1'b0);

`ifdef RESULT_WRITER_CHECKSUM_EN
        beats.delete();
        beats.push_back(64'd1);
        beats.push_back(64'd2);
        beats.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        send_pkt(3, 0, 3);
        check("checksum_wrap", checksum, 64'd2);
        verify(3, 3, 3, 1'b0);
`endif

        // Random packets
        for (int p = 0; p < 8; p++) begin
            int n;
            n = int'($urandom_range(1, 80));
            beats.delete();
            for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
            send_pkt(n, 2, n);
            verify(n, (n < DEPTH) ? n : DEPTH, n, n > DEPTH);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_writer.md
# result_writer

Downstream stage of the data checker. It consumes the checker's AXI4-Stream result packet and writes each beat, in order, into a result BRAM through that BRAM's port A. It then raises a sticky `done` flag with the packet length, for the MMIO/DMA control side to poll and acknowledge. It also bounds the packet against the buffer depth, so an over-long stream can never write past the result region.

## Interface

Parameters:
- `DATA_WIDTH`, 64, stream and BRAM data width (only 64 supported).
- `DEPTH`, 64, result buffer size in words; beats beyond this are dropped.
- `ADDR_BASE`, 32'h0, byte address of word 0 in the BRAM.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `S_AXIS_TDATA` in 64: result data from the checker.
- `S_AXIS_TVALID` in 1: beat valid.
- `S_AXIS_TLAST` in 1: last beat of the packet.
- `S_AXIS_TREADY` out 1: this block accepts a beat.
- `bram_addra` out 32: byte address, `ADDR_BASE + 8*idx`.
- `bram_dina` out 64: write data.
- `bram_ena` out 1: port enable.
- `bram_wea` out 8: byte write enable, `8'hFF` when writing, else `8'h00`.
- `done_ack` in 1: control side clears `done`.
- `done` out 1: packet complete, sticky.
- `pkt_len` out 16: beats accepted in the last or current packet, saturating.
- `overflow` out 1: the last packet had more than `DEPTH` beats.
- `checksum` out 64: only present with `RESULT_WRITER_CHECKSUM_EN`.

## Operation

- A handshake is `S_AXIS_TVALID && S_AXIS_TREADY`.
- `idx` is a write index counting `0..DEPTH`.
- State machine `IDLE`, `RECV`, `DRAIN`, `DONE`. `S_AXIS_TREADY` is 1 in `IDLE`, `RECV` and `DRAIN`, and 0 in `DONE`.
- `IDLE`:
  - On a handshake: clear `pkt_len`, `overflow` and `checksum`; write the beat at `idx` 0; set `pkt_len`=1 and `idx`=1.
  - Next state is `DONE` if `TLAST`, else `RECV`.
- `RECV`: each handshake writes the beat at `idx`, then increments `idx` and `pkt_len`.
  - Handshake with `TLAST` goes to `DONE`.
  - A non-`TLAST` handshake that makes `idx`==`DEPTH` goes to `DRAIN`.
- `DRAIN`: each handshake increments `pkt_len`, sets `overflow`=1 and writes nothing. Handshake with `TLAST` goes to `DONE`.
- `DONE`:
  - `done`=1.
  - `done_ack`=1 goes to `IDLE`, clears `done` and `idx`.
  - `pkt_len` and `overflow` hold until the next packet's first beat.
- `pkt_len` saturates at 16'hFFFF.
- `done_ack` outside `DONE` is ignored.
- `TLAST` on beat number `DEPTH` exactly: the beat is written, `overflow` stays 0, next state is `DONE`.
- Reset mid-packet:
  - All outputs go to their reset values and the partial packet is abandoned.
  - BRAM contents are not cleared.
  - After reset the block is in `IDLE`, so the remainder of the interrupted packet is taken as a new packet.

## Timing

Reset values:
- `state`=`IDLE`, `S_AXIS_TREADY`=0 while `reset` is low.
- `bram_ena`=0, `bram_wea`=0, `bram_addra`=0, `bram_dina`=0.
- `done`=0, `pkt_len`=0, `overflow`=0, `checksum`=0.

Latency and throughput:
- BRAM outputs are registered. A handshake at cycle N drives `bram_ena`=1, `bram_wea`=8'hFF, address and data during cycle N+1, for exactly one cycle per written beat.
- Sustained throughput is 1 beat/cycle, with no bubbles in `IDLE`, `RECV` or `DRAIN`.
- `done` rises in the cycle after the `TLAST` handshake, in the same cycle the last BRAM write is presented. The last word is committed at the end of that cycle.
- `S_AXIS_TREADY` is 0 from the cycle after the `TLAST` handshake until the cycle after `done_ack` is sampled.
- `S_AXIS_TREADY` is a combinational decode of the registered state. It does not depend on `TVALID`.

Handshake rules:
- TVALID may toggle freely; only handshake cycles advance `idx`.

## Configuration

- `RESULT_WRITER_CHECKSUM_EN` defined:
  - `checksum` exists and accumulates the modulo-2^64 sum of every accepted beat, including dropped `DRAIN` beats.
  - It is registered alongside `pkt_len`, valid whenever `done`=1, and cleared on the first beat of a packet.
- Macro undefined: the `checksum` port and accumulator are removed. All other behaviour is identical.

## Test plan

- **Normal packet:** 20 beats of data 1100..1119, TLAST on beat 20, TVALID continuous.
  - 20 one-cycle writes at byte addresses 0x00..0x98 with matching data.
  - `done`=1 one cycle after the last handshake; `pkt_len`=20, `overflow`=0.
- **Single-beat packet:** data 0xABCD with TLAST.
  - One write at address 0; `done`=1; `pkt_len`=1.
  - TREADY=0 until `done_ack`; `done_ack` pulse, then TREADY=1 next cycle.
- **Overflow:** `DEPTH`=64, 70 beats.
  - Exactly 64 writes, last at address 0x1F8; no write for beats 65..70.
  - `overflow`=1, `pkt_len`=70, `done`=1.
- **Backpressure/gaps:** 8 beats with TVALID toggling 1,0,0,1.
  - Writes occur only after handshakes, addresses stay contiguous 0x00..0x38, `pkt_len`=8.
- **Reset mid-packet:** assert `reset` low after beat 5 of 10.
  - All outputs return to reset values at once.
  - Following a 3-beat packet: `pkt_len`=3, writes at addresses 0, 8, 16.
- **Checksum (macro on):** beats 1, 2, 0xFFFFFFFFFFFFFFFF → `checksum`=2 at `done`.
